// File: rtl/bldc_pkg.sv
// rtl/bldc_pkg.sv - shared types and commutation tables for the BLDC drive
package bldc_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int NUM_STEPS = 6;

  function automatic logic [2:0] hall_to_step_cw(input logic [2:0] hall);
    case (hall)
      3'd1:    return 3'd4;
      3'd2:    return 3'd0;
      3'd3:    return 3'd5;
      3'd4:    return 3'd2;
      3'd5:    return 3'd3;
      3'd6:    return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] hall_to_step_ccw(input logic [2:0] hall);
    case (hall)
      3'd1:    return 3'd1;
      3'd2:    return 3'd3;
      3'd3:    return 3'd2;
      3'd4:    return 3'd5;
      3'd5:    return 3'd0;
      3'd6:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Returns {hin, lo_en}; bit 0 = R, bit 1 = S, bit 2 = T.
  function automatic logic [5:0] step_to_gates(input logic [2:0] step);
    case (step)
      3'd0:    return {3'b001, 3'b100};
      3'd1:    return {3'b001, 3'b010};
      3'd2:    return {3'b010, 3'b100};
      3'd3:    return {3'b010, 3'b001};
      3'd4:    return {3'b100, 3'b001};
      3'd5:    return {3'b100, 3'b010};
      default: return 6'b000000;
    endcase
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - free-running PWM counter with duty sampled at period wrap
module pwm_gen #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] duty,
  output logic            pwm_on
);

  logic [BITS-1:0] cnt;
  logic [BITS-1:0] duty_q;

  // duty only moves at the wrap so a period is never cut short or stretched
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      duty_q <= '0;
    end else begin
      cnt <= cnt + BITS'(1);
      if (cnt == '1) duty_q <= duty;
    end
  end

  assign pwm_on = cnt < duty_q;

endmodule

// File: rtl/bldc_commutator.sv
// rtl/bldc_commutator.sv - BLDC forced start / hall commutation with dead-time and low-side PWM
module bldc_commutator
  import bldc_pkg::*;
#(
  parameter int CLK_DIV       = 2700,
  parameter int PWM_BITS      = 8,
  parameter int DEAD_CLKS     = 8,
  parameter int START_TICKS   = 110,
  parameter int WINDOW_TICKS  = 1024,
  parameter int RUN_MIN_EDGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                dir,
  input  logic [PWM_BITS-1:0] duty,
  input  logic [2:0]          hall,
  output logic [2:0]          hin,
  output logic [2:0]          lin_n,
  output logic [2:0]          step,
  output logic                running,
  output logic                hall_fault,
  output logic [7:0]          edge_count
);

  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int START_W = $clog2(START_TICKS + 1);
  localparam int WIN_W   = $clog2(WINDOW_TICKS + 1);
  localparam int DEAD_W  = $clog2(DEAD_CLKS + 1);
  localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

  state_t              state_q, state_d;
  logic [2:0]          hall_m, hall_s, hall_d;
  logic                hall_edge, hall_valid;
  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  logic [START_W-1:0]  start_cnt;
  logic                start_adv;
  logic [WIN_W-1:0]    win_cnt;
  logic [7:0]          edge_cnt, edge_count_q;
  logic                fault_q;
  logic [2:0]          step_q, step_d, step_last;
  logic                gates_active;
  logic [DEAD_W-1:0]   dead_cnt;
  logic [2:0]          hin_q, lin_n_q;
  logic                pwm_on;
  logic [5:0]          gates;
  logic [2:0]          lo_drive;

  assign hall_edge  = hall_s != hall_d;
  assign hall_valid = (hall_s != 3'b000) && (hall_s != 3'b111);
  assign tick       = div_cnt == DIV_W'(CLK_DIV - 1);
  assign start_adv  = tick && (start_cnt == START_W'(START_TICKS - 1));

  // Hall synchroniser, free-running prescaler and speed window.
  always_ff @(posedge clk) begin
    if (rst) begin
      hall_m       <= '0;
      hall_s       <= '0;
      hall_d       <= '0;
      div_cnt      <= '0;
      win_cnt      <= '0;
      edge_cnt     <= '0;
      edge_count_q <= '0;
    end else begin
      hall_m  <= hall;
      hall_s  <= hall_m;
      hall_d  <= hall_s;
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick && (win_cnt == WIN_W'(WINDOW_TICKS - 1))) begin
        win_cnt      <= '0;
        edge_count_q <= edge_cnt;
        edge_cnt     <= hall_edge ? 8'd1 : 8'd0;
      end else begin
        if (tick) win_cnt <= win_cnt + WIN_W'(1);
        if (hall_edge && (edge_cnt != 8'hFF)) edge_cnt <= edge_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (state_q != START)) start_cnt <= '0;
    else if (tick) start_cnt <= start_adv ? '0 : start_cnt + START_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) fault_q <= 1'b0;
    else if ((state_q == RUN) && !hall_valid) fault_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= OFF;
    else     state_q <= state_d;
  end

  // A latched fault keeps the FSM parked in OFF until enable drops.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = OFF;
    end else begin
      case (state_q)
        OFF:     if (!fault_q) state_d = START;
        START:   if (edge_count_q >= 8'(RUN_MIN_EDGES)) state_d = RUN;
        RUN: begin
          if (!hall_valid) state_d = OFF;
          else if (edge_count_q < 8'(RUN_MIN_EDGES)) state_d = START;
        end
        default: state_d = OFF;
      endcase
    end
  end

  always_comb begin
    step_d = step_q;
    if (state_d == RUN) begin
      if (hall_valid) step_d = dir ? hall_to_step_cw(hall_s) : hall_to_step_ccw(hall_s);
    end else if ((state_q == START) && (state_d == START) && start_adv) begin
      if (dir) step_d = (step_q == LAST_STEP) ? 3'd0 : step_q + 3'd1;
      else     step_d = (step_q == 3'd0) ? LAST_STEP : step_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) step_q <= '0;
    else     step_q <= step_d;
  end

  pwm_gen #(
    .BITS(PWM_BITS)
  ) u_pwm (
    .clk   (clk),
    .rst   (rst),
    .duty  (duty),
    .pwm_on(pwm_on)
  );

  assign gates    = step_to_gates(step_q);
  assign lo_drive = gates[2:0] & {3{pwm_on}};

  // Any new step blanks every gate for DEAD_CLKS before its pattern is driven.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_last    <= '0;
      gates_active <= 1'b0;
      dead_cnt     <= '0;
      hin_q        <= 3'b000;
      lin_n_q      <= 3'b111;
    end else begin
      step_last <= step_q;
      if ((state_d == OFF) || (step_q != step_last)) begin
        gates_active <= 1'b0;
        dead_cnt     <= '0;
        hin_q        <= 3'b000;
        lin_n_q      <= 3'b111;
      end else if (gates_active || (dead_cnt == DEAD_W'(DEAD_CLKS - 1))) begin
        gates_active <= 1'b1;
        hin_q        <= gates[5:3];
        lin_n_q      <= ~lo_drive;
      end else begin
        dead_cnt <= dead_cnt + DEAD_W'(1);
        hin_q    <= 3'b000;
        lin_n_q  <= 3'b111;
      end
    end
  end

  assign hin        = hin_q;
  assign lin_n      = lin_n_q;
  assign step       = step_q;
  assign running    = state_q == RUN;
  assign hall_fault = fault_q;
  assign edge_count = edge_count_q;

endmodule

// File: tb/tb_bldc_commutator.sv
// tb/tb_bldc_commutator.sv - directed self-checking bench for bldc_commutator
module tb_bldc_commutator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0, enable_p = 1'b0;
  logic       dir = 1'b1;
  logic [3:0] duty = 4'd15, duty_p = 4'd0;
  logic [2:0] hall = 3'd0, hall_p = 3'd5;
  logic [2:0] hin, lin_n, step, hin_p, lin_n_p, step_p;
  logic       running, hall_fault, running_p, hall_fault_p;
  logic [7:0] edge_count, edge_count_p;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bldc_commutator #(
    .CLK_DIV(4), .PWM_BITS(4), .DEAD_CLKS(8), .START_TICKS(3),
    .WINDOW_TICKS(16), .RUN_MIN_EDGES(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .dir(dir), .duty(duty), .hall(hall),
    .hin(hin), .lin_n(lin_n), .step(step), .running(running),
    .hall_fault(hall_fault), .edge_count(edge_count)
  );

  // Long forced-start steps give the PWM checks a steady step-0 pattern.
  bldc_commutator #(
    .CLK_DIV(4), .PWM_BITS(4), .DEAD_CLKS(8), .START_TICKS(250),
    .WINDOW_TICKS(16), .RUN_MIN_EDGES(2)
  ) dut_pwm (
    .clk(clk), .rst(rst), .enable(enable_p), .dir(dir), .duty(duty_p), .hall(hall_p),
    .hin(hin_p), .lin_n(lin_n_p), .step(step_p), .running(running_p),
    .hall_fault(hall_fault_p), .edge_count(edge_count_p)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_step(input int limit, output int n, output logic ok);
    logic [2:0] prev;
    prev = step;
    ok = 1'b0;
    n = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      n++;
      if (step != prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_lows(input int n, output int lows, inout int stray);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!lin_n_p[2]) lows++;
      if ((lin_n_p[1:0] != 2'b11) || (hin_p != 3'b001)) stray++;
    end
  endtask

  task automatic enter_run(output logic found);
    logic [2:0] cw_tbl [6];
    cw_tbl = '{3'd2, 3'd6, 3'd4, 3'd5, 3'd1, 3'd3};
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      hall = cw_tbl[i % 6];
      repeat (10) @(negedge clk);
      if (running) found = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert (((hin & ~lin_n) | (hin_p & ~lin_n_p)) == 3'b000) else begin
        failures++;
        $error("FAIL shoot_through hin=%b lin_n=%b hin_p=%b lin_n_p=%b", hin, lin_n, hin_p, lin_n_p);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lows, stray, offc, bad;
    logic ok, seen;
    logic [2:0] saved;

    // Reset and idle with enable low
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_hin", hin, 3'b000);
    check("rst_lin_n", lin_n, 3'b111);
    check("rst_step", step, 0);
    check("rst_running", running, 0);
    check("rst_hall_fault", hall_fault, 0);
    check("rst_edge_count", edge_count, 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hin != 3'b000 || lin_n != 3'b111 || step != 3'd0 || running || edge_count != 8'd0) bad++;
    end
    check("idle_100_unchanged", bad, 0);

    // PWM on the long-start instance
    stray = 0;
    duty_p = 4'd5;
    enable_p = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (hin_p == 3'b001) ok = 1'b1;
    end
    check("pwm_pattern_applied", ok, 1);
    repeat (16) @(negedge clk);
    ok = 1'b0;
    seen = lin_n_p[2];
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (seen && !lin_n_p[2]) begin
        ok = 1'b1;
        break;
      end
      seen = lin_n_p[2];
    end
    check("pwm_period_found", ok, 1);
    count_lows(15, lows, stray);
    check("pwm_duty5_period", lows + 1, 5);
    count_lows(8, lows, stray);
    check("pwm_duty5_first_half", lows, 5);
    duty_p = 4'd9;
    count_lows(8, lows, stray);
    check("pwm_mid_change_held", lows, 0);
    count_lows(16, lows, stray);
    check("pwm_duty9_period", lows, 9);
    duty_p = 4'd0;
    count_lows(16, lows, stray);
    count_lows(32, lows, stray);
    check("pwm_duty0", lows, 0);
    duty_p = 4'd15;
    count_lows(16, lows, stray);
    count_lows(16, lows, stray);
    check("pwm_duty15", lows, 15);
    check("pwm_other_phases_off", stray, 0);
    enable_p = 1'b0;

    // Forced start, CW then CCW, with dead-time on a 0->1 change
    hall = 3'd5;
    dir = 1'b1;
    enable = 1'b1;
    wait_step(80, n, ok);
    check("start_first_ok", ok, 1);
    check("start_first_step", step, 1);
    for (int k = 2; k <= 6; k++) begin
      wait_step(30, n, ok);
      check("start_cw_step", step, k % 6);
      check("start_cw_period", n, 12);
    end
    wait_step(30, n, ok);
    check("dead_step_now_1", step, 1);
    check("dead_old_pattern", hin, 3'b001);
    dir = 1'b0;
    offc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (hin == 3'b000 && lin_n == 3'b111) offc++;
      else break;
    end
    check("dead_off_clks", offc, 8);
    check("dead_new_hin", hin, 3'b001);
    check("dead_new_lo_only_s", lin_n & 3'b101, 3'b101);
    seen = (lin_n == 3'b101);
    @(negedge clk);
    if (lin_n == 3'b101) seen = 1'b1;
    check("dead_new_lo_s_on", seen, 1);
    wait_step(30, n, ok);
    check("start_ccw_1_to_0", step, 0);
    wait_step(30, n, ok);
    check("start_ccw_0_to_5", step, 5);
    check("start_ccw_period", n, 12);
    wait_step(30, n, ok);
    check("start_ccw_5_to_4", step, 4);

    // Closed loop on halls
    dir = 1'b1;
    enter_run(ok);
    check("run_entered", ok, 1);
    check("run_edges_min", edge_count >= 8'd2, 1);
    hall = 3'd6;
    repeat (12) @(negedge clk);
    check("run_cw_hall6", step, 1);
    hall = 3'd4;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("run_latency_2clk", step, 1);
    @(negedge clk);
    check("run_latency_3clk", step, 2);
    dir = 1'b0;
    repeat (2) @(negedge clk);
    check("run_ccw_hall4", step, 5);
    hall = 3'd1;
    repeat (4) @(negedge clk);
    check("run_ccw_hall1", step, 1);
    dir = 1'b1;
    repeat (2) @(negedge clk);
    check("run_cw_hall1", step, 4);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (!running) ok = 1'b1;
    end
    check("run_drop_on_stall", ok, 1);
    check("run_drop_edges", edge_count < 8'd2, 1);

    // Hall fault and recovery
    enter_run(ok);
    check("fault_run_entered", ok, 1);
    hall = 3'd6;
    repeat (12) @(negedge clk);
    saved = step;
    hall = 3'd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("fault_flag", hall_fault, 1);
    check("fault_hin_off", hin, 3'b000);
    check("fault_lin_off", lin_n, 3'b111);
    check("fault_not_running", running, 0);
    check("fault_step_held", step, saved);
    repeat (10) @(negedge clk);
    check("fault_sticky", hall_fault, 1);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("fault_cleared", hall_fault, 0);
    repeat (150) @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    check("restart_not_running", running, 0);
    check("restart_no_fault", hall_fault, 0);
    wait_step(40, n, ok);
    check("restart_start_steps", ok, 1);

    // Reset while running
    enter_run(ok);
    check("rst_run_entered", ok, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst2_hin", hin, 3'b000);
    check("rst2_lin_n", lin_n, 3'b111);
    check("rst2_step", step, 0);
    check("rst2_running", running, 0);
    check("rst2_hall_fault", hall_fault, 0);
    check("rst2_edge_count", edge_count, 0);
    rst = 1'b0;
    enable = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bldc_commutator.md
Name: bldc_commutator

Overview:
Parametrised three-phase BLDC commutation and PWM stage. Replaces the ad-hoc rotate/duty logic in the top level with a single block that provides:
- open-loop forced start, then hall-sensor closed-loop commutation;
- CW/CCW selection;
- N-bit low-side PWM;
- programmable dead-time on every step change;
- invalid-hall fault detection.
Sits between the user controls/ADC-derived duty and the gate-driver pins (HIN_x high-side active-high, LIN_x low-side active-low).

Parameters:
CLK_DIV, 2700, clk cycles per control tick (100 us at 27 MHz); min 2
PWM_BITS, 8, duty/PWM counter width; PWM period = 2^PWM_BITS clk
DEAD_CLKS, 8, clk cycles all switches off between two different step patterns; min 1
START_TICKS, 110, ticks per forced step in open-loop start
WINDOW_TICKS, 1024, speed-measurement window in ticks
RUN_MIN_EDGES, 2, hall edges per window needed to enter/stay in closed loop

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
enable  in  1  1 = drive motor; 0 = all switches off, FSM to OFF
dir  in  1  1 = CW, 0 = CCW
duty  in  PWM_BITS  low-side on-time, in clk cycles per PWM period
hall  in  3  raw hall inputs (asynchronous)
hin  out  3  high-side gates [0]=R [1]=S [2]=T, active-high
lin_n  out  3  low-side gates R/S/T, active-low
step  out  3  current commutation step 0..5
running  out  1  1 in RUN state
hall_fault  out  1  sticky invalid-hall flag
edge_count  out  8  hall edges counted in last complete window, saturating at 255

Behaviour:
- Reset values:
  - hin=000, lin_n=111, step=0, running=0, hall_fault=0, edge_count=0.
  - State OFF; all counters 0; hall synchroniser cleared to 000.
- Clocking:
  - hall passes a 2-FF synchroniser.
  - Control tick = 1-clk pulse every CLK_DIV clk, generated by an internal prescaler. The prescaler is free-running; it does not reset on enable.
- FSM:
  - OFF: outputs off. Goes to START when enable=1.
  - START: step advances on every START_TICKS-th tick. CW increments 5→0; CCW decrements 0→5.
  - RUN: step is set from the synchronised hall on every clk.
    - CW map: 1→4, 2→0, 3→5, 4→2, 5→3, 6→1.
    - CCW map: 1→1, 2→3, 3→2, 4→5, 5→0, 6→4.
  - Any state → OFF when enable=0; this takes priority over all other transitions.
  - Latency from a raw hall change to the new step value: 3 clk.
- Speed window:
  - A tick counter wraps every WINDOW_TICKS ticks.
  - Every change of synchronised hall increments an edge counter, saturating at 255.
  - At wrap: edge_count ← counter, counter ← 0. An edge on the wrap cycle is counted in the new window.
  - START→RUN when the latched value ≥ RUN_MIN_EDGES; RUN→START when it is < RUN_MIN_EDGES.
  - On START→RUN, step is immediately taken from hall.
- Step patterns (phase high / phase low), with the third phase fully off:
  - 0: R/T; 1: R/S; 2: S/T; 3: S/R; 4: T/R; 5: T/S.
- Dead-time:
  - When the registered step differs from the pattern currently applied, all gates are off (hin=000, lin_n=111) for DEAD_CLKS clk, then the new pattern is applied.
  - A further step change during dead-time restarts the count, and the newest step is applied.
  - Entering OFF forces gates off at once, with no dead-time wait.
- PWM:
  - A free-running PWM_BITS counter runs on clk. The low-side switch is on only while pwm_cnt < duty; the high side stays on for the whole step.
  - duty=0 → low side never on. duty=2^PWM_BITS−1 → on for all but 1 clk per period.
  - duty is sampled at pwm_cnt wrap, so there are no mid-period glitches.
- Hall fault:
  - In RUN, synchronised hall = 000 or 111 → hall_fault=1, gates off, step held.
  - Cleared only by rst or enable=0. While set with enable=1, the FSM stays in OFF-equivalent with gates off.
- Outputs are registered; no combinational path from inputs to hin/lin_n.
- Shoot-through invariant: for every phase, hin[i]=1 and lin_n[i]=0 never occur on the same clk.

Decomposition:
- Package bldc_pkg:
  - enum state_t {OFF, START, RUN};
  - commutation map functions hall_to_step_cw/ccw;
  - step_to_gates function returning {hin, lo_en};
  - constant NUM_STEPS=6.
- One sub-module, pwm_gen (free-running counter, sampled duty, pwm_on output), reusable for other drives.
- Prescaler, FSM, window counter and dead-time logic stay in bldc_commutator.

Test Plan:
1. Reset → hin=000, lin_n=111, step=0, running=0, edge_count=0. Hold enable=0 for 100 clk → outputs unchanged.
2. CLK_DIV=4, START_TICKS=3, dir=1, enable=1, hall static 5 → step advances 0,1,2…5,0 every 12 clk; dir=0 → decrements 0→5.
3. WINDOW_TICKS=16, hall cycling 2→6→4→5→1→3 faster than RUN_MIN_EDGES per window → running=1, step follows CW map (hall 4 → step 2 three clk after the change). Stopping hall → running=0 after next window.
4. DEAD_CLKS=8, step change 0→1 → hin=000, lin_n=111 for exactly 8 clk, then hin=001, low side on S. Check the shoot-through invariant every cycle.
5. PWM_BITS=4, duty=5 → lin_n low on the active phase for 5 of every 16 clk. duty=0 → lin_n=111 constantly. Change duty mid-period → takes effect next period.
6. In RUN, hall=111 → hall_fault=1 and gates off within 3 clk. enable 1→0→1 → fault cleared, FSM restarts in START. rst asserted mid-RUN → all reset values on the next clk.
